// File: rtl/motor_pwm_driver.sv
// Dual-channel slew-limited PWM driver for the left/right motor H-bridge enables.
// Speed commands are sampled once per PWM period and ramped toward at most RAMP_STEP ticks per period.
module motor_pwm_driver #(
    parameter int unsigned PRESCALE   = 4,
    parameter int unsigned PWM_PERIOD = 100,
    parameter int unsigned RAMP_STEP  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] cmd_left,
    input  logic [7:0] cmd_right,
    output logic       pwm_left,
    output logic       pwm_right,
    output logic [7:0] duty_left,
    output logic [7:0] duty_right,
    output logic       period_start,
    output logic       ramping
);

    localparam int unsigned PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [7:0]      CNT_LAST = 8'(PWM_PERIOD - 1);
    localparam logic [8:0]      FULL     = 9'(PWM_PERIOD);
    localparam logic [8:0]      STEP     = (RAMP_STEP > 255) ? 9'd255 : 9'(RAMP_STEP);

    logic [PS_W-1:0] prescale_cnt;
    logic [7:0]      period_cnt;
    logic [7:0]      target_left;
    logic [7:0]      target_right;

    logic            tick_c;
    logic            wrap_c;
    logic [PS_W-1:0] prescale_nxt;
    logic [7:0]      period_nxt;
    logic [7:0]      target_left_nxt;
    logic [7:0]      target_right_nxt;
    logic [7:0]      duty_left_nxt;
    logic [7:0]      duty_right_nxt;
    logic            pwm_left_nxt;
    logic            pwm_right_nxt;
    logic            period_start_nxt;
    logic            ramping_nxt;

    // Commands above full scale mean 100% duty.
    function automatic logic [7:0] clamp_cmd(input logic [7:0] cmd);
        return ({1'b0, cmd} > FULL) ? FULL[7:0] : cmd;
    endfunction

    // One slew step toward the target, done in 9 bits so the difference never wraps.
    function automatic logic [7:0] ramp_toward(input logic [7:0] duty, input logic [7:0] target);
        logic [8:0] d;
        logic [8:0] t;
        d = {1'b0, duty};
        t = {1'b0, target};
        if (t >= d) begin
            return ((t - d) <= STEP) ? target : 8'(d + STEP);
        end
        return ((d - t) <= STEP) ? target : 8'(d - STEP);
    endfunction

    always_comb begin
        tick_c = (prescale_cnt == PS_LAST);
        wrap_c = tick_c && (period_cnt == CNT_LAST);

        prescale_nxt     = tick_c ? '0 : prescale_cnt + PS_W'(1);
        period_nxt       = period_cnt;
        target_left_nxt  = target_left;
        target_right_nxt = target_right;
        duty_left_nxt    = duty_left;
        duty_right_nxt   = duty_right;
        ramping_nxt      = ramping;
        period_start_nxt = 1'b0;

        if (tick_c) begin
            period_nxt = wrap_c ? 8'd0 : period_cnt + 8'd1;
        end

        // Period boundary: sample commands and take one slew step per channel.
        if (wrap_c) begin
            target_left_nxt  = clamp_cmd(cmd_left);
            target_right_nxt = clamp_cmd(cmd_right);
            duty_left_nxt    = ramp_toward(duty_left, target_left_nxt);
            duty_right_nxt   = ramp_toward(duty_right, target_right_nxt);
            ramping_nxt      = (duty_left_nxt != target_left_nxt) ||
                               (duty_right_nxt != target_right_nxt);
            period_start_nxt = 1'b1;
        end

        if (!enable) begin
            prescale_nxt     = '0;
            period_nxt       = 8'd0;
            target_left_nxt  = 8'd0;
            target_right_nxt = 8'd0;
            duty_left_nxt    = 8'd0;
            duty_right_nxt   = 8'd0;
            ramping_nxt      = 1'b0;
            period_start_nxt = 1'b0;
        end

        // Compare against next-state values so the registered output lines up with the counters.
        pwm_left_nxt  = enable && (period_nxt < duty_left_nxt);
        pwm_right_nxt = enable && (period_nxt < duty_right_nxt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale_cnt <= '0;
            period_cnt   <= 8'd0;
            target_left  <= 8'd0;
            target_right <= 8'd0;
            duty_left    <= 8'd0;
            duty_right   <= 8'd0;
            pwm_left     <= 1'b0;
            pwm_right    <= 1'b0;
            period_start <= 1'b0;
            ramping      <= 1'b0;
        end else begin
            prescale_cnt <= prescale_nxt;
            period_cnt   <= period_nxt;
            target_left  <= target_left_nxt;
            target_right <= target_right_nxt;
            duty_left    <= duty_left_nxt;
            duty_right   <= duty_right_nxt;
            pwm_left     <= pwm_left_nxt;
            pwm_right    <= pwm_right_nxt;
            period_start <= period_start_nxt;
            ramping      <= ramping_nxt;
        end
    end

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver: table-driven ramp scenarios, hand-written corner sequences,
// and randomized commands checked every cycle against a phase-counter reference model.
module tb_motor_pwm_driver;

    localparam int PRESCALE    = 4;
    localparam int PWM_PERIOD  = 100;
    localparam int RAMP_STEP   = 5;
    localparam int PERIOD_CLKS = PRESCALE * PWM_PERIOD;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] cmd_left = 8'd0;
    logic [7:0] cmd_right = 8'd0;
    logic       pwm_left;
    logic       pwm_right;
    logic [7:0] duty_left;
    logic [7:0] duty_right;
    logic       period_start;
    logic       ramping;

    int total = 0;
    int bad   = 0;

    // Reference model: clocks elapsed in the current period, plus applied duties/targets.
    int m_phase, m_dl, m_dr, m_tl, m_tr;
    bit m_ps, m_ramp;

    typedef struct {
        logic [7:0] cl;
        logic [7:0] cr;
        int         n;
        int         dl;
        int         dr;
        bit         rmp;
        int         hl;
        int         hr;
    } row_t;

    row_t rows[10];

    motor_pwm_driver #(
        .PRESCALE  (PRESCALE),
        .PWM_PERIOD(PWM_PERIOD),
        .RAMP_STEP (RAMP_STEP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cmd_left    (cmd_left),
        .cmd_right   (cmd_right),
        .pwm_left    (pwm_left),
        .pwm_right   (pwm_right),
        .duty_left   (duty_left),
        .duty_right  (duty_right),
        .period_start(period_start),
        .ramping     (ramping)
    );

    always #5 clk = ~clk;

    function automatic int approach(int duty, int tgt);
        if (tgt > duty + RAMP_STEP) return duty + RAMP_STEP;
        if (tgt < duty - RAMP_STEP) return duty - RAMP_STEP;
        return tgt;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_dl = 0; m_dr = 0; m_tl = 0; m_tr = 0;
        m_ps = 1'b0; m_ramp = 1'b0;
    endtask

    task automatic model_step();
        if (reset || !enable) begin
            model_reset();
        end else begin
            m_phase = m_phase + 1;
            m_ps = 1'b0;
            if (m_phase == PERIOD_CLKS) begin
                m_phase = 0;
                m_ps = 1'b1;
                m_tl = (int'(cmd_left) > PWM_PERIOD) ? PWM_PERIOD : int'(cmd_left);
                m_tr = (int'(cmd_right) > PWM_PERIOD) ? PWM_PERIOD : int'(cmd_right);
                m_dl = approach(m_dl, m_tl);
                m_dr = approach(m_dr, m_tr);
                m_ramp = (m_dl != m_tl) || (m_dr != m_tr);
            end
        end
    endtask

    function automatic logic [19:0] model_out();
        logic pl, pr;
        pl = (m_phase / PRESCALE) < m_dl;
        pr = (m_phase / PRESCALE) < m_dr;
        return {pl, pr, 8'(m_dl), 8'(m_dr), m_ps, m_ramp};
    endfunction

    function automatic logic [19:0] dut_out();
        return {pwm_left, pwm_right, duty_left, duty_right, period_start, ramping};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model at the edge, compare all outputs just after it.
    task automatic cycle();
        logic [19:0] exp_o;
        logic [19:0] act_o;
        @(posedge clk);
        model_step();
        #1;
        exp_o = model_out();
        act_o = dut_out();
        total++;
        if (act_o !== exp_o) begin
            bad++;
            $display("FAIL outputs: got %h expected %h (pwmL pwmR dutyL dutyR ps ramp) at %0t",
                     act_o, exp_o, $time);
        end
    endtask

    task automatic wait_ps(input int n);
        for (int i = 0; i < n; i++) begin
            int k;
            k = 0;
            do begin
                cycle();
                k++;
            end while (!period_start && k < PERIOD_CLKS + 8);
            if (!period_start) check("period_start_timeout", 0, 1);
        end
    endtask

    // Cycles from now until the next period_start, bounded.
    task automatic cycles_to_ps(output int k);
        k = 0;
        do begin
            cycle();
            k++;
        end while (!period_start && k < 2 * PERIOD_CLKS);
    endtask

    function automatic logic [7:0] pick_cmd();
        if ($urandom_range(0, 9) == 0) return 8'($urandom_range(101, 255));
        return 8'($urandom_range(0, 100));
    endfunction

    initial begin
        int hl, hr, k;
        bit held;

        rows[0] = '{8'd50,  8'd50,  8, 45,  45, 1'b1, 180, 180};
        rows[1] = '{8'd50,  8'd50,  1, 50,  50, 1'b0, 200, 200};
        rows[2] = '{8'd50,  8'd30,  4, 50,  30, 1'b0, 200, 120};
        rows[3] = '{8'd30,  8'd50,  1, 45,  35, 1'b1, 180, 140};
        rows[4] = '{8'd30,  8'd50,  3, 30,  50, 1'b0, 120, 200};
        rows[5] = '{8'd200, 8'd50, 14, 100, 50, 1'b0, 400, 200};
        rows[6] = '{8'd200, 8'd50,  1, 100, 50, 1'b0, 400, 200};
        rows[7] = '{8'd0,   8'd50, 19, 5,   50, 1'b1, 20,  200};
        rows[8] = '{8'd0,   8'd50,  1, 0,   50, 1'b0, 0,   200};
        rows[9] = '{8'd40,  8'd50,  8, 40,  50, 1'b0, 160, 200};

        model_reset();
        #2 reset = 1'b1;
        #1 check("reset_outputs", int'(dut_out()), 0);
        repeat (3) cycle();
        reset = 1'b0;
        enable = 1'b1;
        cmd_left = 8'd50;
        cmd_right = 8'd50;

        // First boundary arrives one full period after release, ramp starts at one step.
        cycles_to_ps(k);
        check("first_period_len", k, PERIOD_CLKS);
        check("first_duty_left", int'(duty_left), 5);
        check("first_duty_right", int'(duty_right), 5);

        for (int r = 0; r < 10; r++) begin
            cmd_left = rows[r].cl;
            cmd_right = rows[r].cr;
            wait_ps(rows[r].n);
            check($sformatf("row%0d_duty_left", r), int'(duty_left), rows[r].dl);
            check($sformatf("row%0d_duty_right", r), int'(duty_right), rows[r].dr);
            check($sformatf("row%0d_ramping", r), int'(ramping), int'(rows[r].rmp));
            hl = int'(pwm_left);
            hr = int'(pwm_right);
            for (int c = 1; c < PERIOD_CLKS; c++) begin
                cycle();
                hl += int'(pwm_left);
                hr += int'(pwm_right);
            end
            check($sformatf("row%0d_high_left", r), hl, rows[r].hl);
            check($sformatf("row%0d_high_right", r), hr, rows[r].hr);
        end

        // Command change at period_cnt 37 must not disturb the current period.
        wait_ps(1);
        hl = int'(pwm_left);
        for (int c = 0; c < 37 * PRESCALE; c++) begin
            cycle();
            hl += int'(pwm_left);
        end
        cmd_left = 8'd80;
        held = 1'b1;
        for (int c = 37 * PRESCALE + 1; c < PERIOD_CLKS; c++) begin
            cycle();
            hl += int'(pwm_left);
            if (duty_left != 8'd40) held = 1'b0;
        end
        check("midperiod_duty_held", int'(held), 1);
        check("midperiod_high_left", hl, 160);
        wait_ps(1);
        check("midperiod_next_duty", int'(duty_left), 45);

        // Enable drop mid-period forces everything to zero on the next edge.
        cmd_left = 8'd40;
        wait_ps(1);
        check("pre_disable_duty", int'(duty_left), 40);
        repeat (60) cycle();
        enable = 1'b0;
        cycle();
        check("disable_pwm_left", int'(pwm_left), 0);
        check("disable_duty_left", int'(duty_left), 0);
        check("disable_duty_right", int'(duty_right), 0);
        check("disable_ramping", int'(ramping), 0);
        repeat (5) cycle();
        enable = 1'b1;
        cycles_to_ps(k);
        check("reenable_period_len", k, PERIOD_CLKS);
        check("reenable_duty_left", int'(duty_left), 5);

        // Asynchronous reset between edges clears outputs immediately.
        wait_ps(4);
        check("pre_reset_duty", int'(duty_left), 25);
        repeat (30) cycle();
        #2 reset = 1'b1;
        model_reset();
        #1 check("async_reset_outputs", int'(dut_out()), 0);
        repeat (3) cycle();
        reset = 1'b0;
        cycles_to_ps(k);
        check("post_reset_period_len", k, PERIOD_CLKS);
        check("post_reset_duty_left", int'(duty_left), 5);

        // Randomized commands and enable toggles against the model.
        for (int c = 0; c < 8000; c++) begin
            if ($urandom_range(0, 49) == 0) cmd_left = pick_cmd();
            if ($urandom_range(0, 49) == 0) cmd_right = pick_cmd();
            if (enable && $urandom_range(0, 999) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/motor_pwm_driver.md
Name: motor_pwm_driver

Overview:
Dual-channel PWM generator that consumes the per-motor 8-bit speed commands produced by the line-following controller and drives the left and right motor H-bridge enable pins. Commands are sampled once per PWM period and slew-rate limited, so the duty cycle never jumps by more than RAMP_STEP per period. Output waveforms are glitch-free. The block sits between the line-following logic and the motor driver pins.

Parameters:
PRESCALE, 4, clk cycles per PWM tick (>=1)
PWM_PERIOD, 100, PWM ticks per period; duty full scale (2..255)
RAMP_STEP, 5, max duty change in ticks per period (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high
enable  input  1  1 = drive motors; 0 = force stop
cmd_left  input  8  requested left duty in ticks (level, may change any cycle)
cmd_right  input  8  requested right duty in ticks
pwm_left  output  1  left motor PWM
pwm_right  output  1  right motor PWM
duty_left  output  8  currently applied left duty
duty_right  output  8  currently applied right duty
period_start  output  1  1-cycle pulse on each period wrap
ramping  output  1  1 while either applied duty differs from its sampled target

Behaviour:
- Interface decision: reset is asynchronous and active-high; the clock is clk.
- Reset, applied immediately with no clock edge needed: prescale_cnt=0, period_cnt=0, duty_left/right=0, targets=0, pwm_left/right=0, period_start=0, ramping=0.
- prescale_cnt counts 0..PRESCALE-1. A tick occurs on a cycle where prescale_cnt==PRESCALE-1.
- period_cnt advances by 1 on each tick and wraps from PWM_PERIOD-1 to 0. This wrap edge is the period boundary.
- On the boundary edge, for each channel:
  - target = min(cmd, PWM_PERIOD). Any cmd above PWM_PERIOD clamps to 100%.
  - If |target-duty| <= RAMP_STEP, duty becomes target. Otherwise duty moves RAMP_STEP toward target.
  - Use 9-bit arithmetic so nothing underflows or overflows.
- duty changes only on the boundary edge. A cmd change mid-period has no effect until the next boundary.
- pwm_x is registered and computed from next-state values, so in every cycle pwm_x == enable && (period_cnt < duty_x).
  - This gives exactly duty_x*PRESCALE high clocks per period.
  - duty=0 means constant low. duty=PWM_PERIOD means constant high, including across the wrap with no glitch.
- period_start is 1 in the cycle where period_cnt==0 after a wrap. It is coincident with the first cycle of the new duty. It does not assert for the period that begins at reset release or at enable rise.
- ramping is registered and updated on the boundary edge: ramping = (new duty_left != target_left) || (new duty_right != target_right). It deasserts in the same cycle duty reaches target.
- enable=0 is a synchronous override. On the next edge, counters, duties, targets, pwm and ramping all go to 0. They hold there while enable=0.
- enable rising: counting starts from 0. The first sample happens at the end of the first full period, so the ramp restarts from duty 0.
- No first-period sampling: after reset or enable, the motors stay at 0 for one full period.
- Both channels are fully independent apart from the shared counters.

Test Plan:
1. Reset, enable=1, cmd_left=cmd_right=50 -> duty 0 for the first period, then 5,10,...,50 at successive period_start pulses. ramping drops with duty=50 at the 10th boundary. Then pwm_left is high 200 of every 400 clks.
2. Settled at 50/30, then cmd_left=30, cmd_right=50 -> left 45,40,35,30 and right 35,40,45,50 over 4 boundaries. Final high counts are left 120/400 and right 200/400 clks.
3. cmd_left=200 settled -> duty_left=100 and pwm_left constant high across wraps, with no low cycle. Then cmd_left=0 -> ramps down 5/period to constant low.
4. Change cmd_left at period_cnt=37 -> duty_left and pwm_left are unchanged until the next boundary. No runt pulse appears.
5. Drop enable mid-period at duty 40 -> next cycle pwm=0, duty=0, period_cnt=0. Re-enable with cmd 40 -> first change at the end of the first period, to 5.
6. Assert reset asynchronously between edges at duty 25 -> all outputs 0 before the next clk edge. After release the ramp restarts from 0.
